// File: rtl/matmul_tile_scheduler_pkg.sv
// matmul_tile_scheduler_pkg
// Shared definitions for the tiled matrix-multiply job scheduler:
//   - default array/matrix geometry (systolic edge, output edge, tiles per edge)
//   - tile index width and per-job address stride defaults
//   - scheduler state encoding
package matmul_tile_scheduler_pkg;

    localparam int WIDTH_HEIGHT_DEFAULT     = 16;
    localparam int WIDTH_HEIGHT_OUT_DEFAULT = 128;
    localparam int MAT_NUM_DEFAULT          = WIDTH_HEIGHT_OUT_DEFAULT / WIDTH_HEIGHT_DEFAULT;
    localparam int IDX_WIDTH_DEFAULT        = $clog2(MAT_NUM_DEFAULT);
    localparam int TILE_STRIDE_DEFAULT      = WIDTH_HEIGHT_DEFAULT * WIDTH_HEIGHT_DEFAULT;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        ADVANCE   = 3'd4,
        FINISH    = 3'd5
    } state_t;

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// matmul_tile_scheduler_if
// Job bus between the tile scheduler (master) and the multiply controller (slave).
//   mult_active    : one-cycle job request, scheduler -> controller
//   mult_done      : controller idle flag (high while in HOLD), controller -> scheduler
//   submatrix_row  : accumulator-table row of the current job
//   submatrix_col  : accumulator-table col of the current job
//   k_idx          : reduction index of the current job
//   accum_first    : overwrite (rather than accumulate) for k_idx == 0
//   job_addr       : base address of the current job
interface matmul_tile_scheduler_if #(
    parameter int ADDR_WIDTH = matmul_tile_scheduler_pkg::WIDTH_HEIGHT_DEFAULT * 8,
    parameter int IDX_WIDTH  = matmul_tile_scheduler_pkg::IDX_WIDTH_DEFAULT
);

    logic                  mult_active;
    logic                  mult_done;
    logic [IDX_WIDTH-1:0]  submatrix_row;
    logic [IDX_WIDTH-1:0]  submatrix_col;
    logic [IDX_WIDTH-1:0]  k_idx;
    logic                  accum_first;
    logic [ADDR_WIDTH-1:0] job_addr;

    modport master (
        output mult_active, submatrix_row, submatrix_col, k_idx, accum_first, job_addr,
        input  mult_done
    );

    modport slave (
        input  mult_active, submatrix_row, submatrix_col, k_idx, accum_first, job_addr,
        output mult_done
    );

endinterface

// File: rtl/matmul_tile_scheduler_tile_index_counter.sv
// tile_index_counter
// Nested row/col/k tile counter; k is innermost, row outermost.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : return all indices to zero
//   inc        : step to the next (row, col, k) position
//   *_m1       : inclusive upper limits of each index
//   row/col/k  : current indices (registered)
//   k_first    : registered flag, high when k == 0
//   last       : current position is the final one of the sequence
module tile_index_counter
    import matmul_tile_scheduler_pkg::*;
#(
    parameter int IDX_WIDTH = IDX_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [IDX_WIDTH-1:0] row_m1,
    input  logic [IDX_WIDTH-1:0] col_m1,
    input  logic [IDX_WIDTH-1:0] k_m1,
    output logic [IDX_WIDTH-1:0] row,
    output logic [IDX_WIDTH-1:0] col,
    output logic [IDX_WIDTH-1:0] k,
    output logic                 k_first,
    output logic                 last
);

    assign last = (row == row_m1) && (col == col_m1) && (k == k_m1);

    // k_first is kept as its own flop so accum_first leaves the block registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            k       <= '0;
            k_first <= 1'b1;
        end else if (clear) begin
            row     <= '0;
            col     <= '0;
            k       <= '0;
            k_first <= 1'b1;
        end else if (inc) begin
            if (k != k_m1) begin
                k       <= k + 1'b1;
                k_first <= 1'b0;
            end else begin
                k       <= '0;
                k_first <= 1'b1;
                if (col != col_m1) begin
                    col <= col + 1'b1;
                end else begin
                    col <= '0;
                    if (row != row_m1) begin
                        row <= row + 1'b1;
                    end else begin
                        row <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler
// Issues one sub-matrix job at a time to the multiply controller, walking
// output tiles (row, col) and the reduction index k of a tiled matmul.
//   clk, reset       : clock, asynchronous active-high reset
//   start            : begin a job sequence (sampled in IDLE only)
//   row/col/k_tiles_m1 : tile counts minus one, latched on accepted start
//   base_addr        : address of the first job, latched on accepted start
//   busy             : high outside IDLE
//   done             : one-cycle pulse after the last job completes
//   ctrl             : job bus to the multiply controller (master side)
module matmul_tile_scheduler
    import matmul_tile_scheduler_pkg::*;
#(
    parameter int WIDTH_HEIGHT     = WIDTH_HEIGHT_DEFAULT,
    parameter int ADDR_WIDTH       = WIDTH_HEIGHT * 8,
    parameter int WIDTH_HEIGHT_OUT = WIDTH_HEIGHT_OUT_DEFAULT,
    parameter int MAT_NUM          = WIDTH_HEIGHT_OUT / WIDTH_HEIGHT,
    parameter int TILE_STRIDE      = WIDTH_HEIGHT * WIDTH_HEIGHT,
    localparam int IDX_WIDTH       = $clog2(MAT_NUM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [IDX_WIDTH-1:0]     row_tiles_m1,
    input  logic [IDX_WIDTH-1:0]     col_tiles_m1,
    input  logic [IDX_WIDTH-1:0]     k_tiles_m1,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    output logic                     busy,
    output logic                     done,
    matmul_tile_scheduler_if.master  ctrl
);

    state_t                state_q, state_d;
    logic                  active_q, active_d;
    logic                  busy_q, done_q;
    logic                  cnt_inc, cnt_clear, cnt_last;
    logic [IDX_WIDTH-1:0]  row_m1_q, col_m1_q, k_m1_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    tile_index_counter #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .row_m1  (row_m1_q),
        .col_m1  (col_m1_q),
        .k_m1    (k_m1_q),
        .row     (ctrl.submatrix_row),
        .col     (ctrl.submatrix_col),
        .k       (ctrl.k_idx),
        .k_first (ctrl.accum_first),
        .last    (cnt_last)
    );

    assign ctrl.mult_active = active_q;
    assign ctrl.job_addr    = addr_q;
    assign busy             = busy_q;
    assign done             = done_q;

    // State register plus registered outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == FINISH);
        end
    end

    // ISSUE raises the request only once the controller reports HOLD; a request
    // that went out this cycle (active_q) moves on to wait for the acknowledge.
    always_comb begin
        state_d   = state_q;
        active_d  = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ISSUE;
                    active_d = ctrl.mult_done;
                end
            end
            ISSUE: begin
                if (active_q) begin
                    state_d = WAIT_ACK;
                end else begin
                    active_d = ctrl.mult_done;
                end
            end
            WAIT_ACK: begin
                if (!ctrl.mult_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (ctrl.mult_done) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (cnt_last) begin
                    state_d   = FINISH;
                    cnt_clear = 1'b1;
                end else begin
                    state_d  = ISSUE;
                    cnt_inc  = 1'b1;
                    active_d = ctrl.mult_done;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration is captured on an accepted start; the job address steps by
    // one tile per job and wraps naturally at ADDR_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_m1_q <= '0;
            col_m1_q <= '0;
            k_m1_q   <= '0;
            addr_q   <= '0;
        end else if (state_q == IDLE && start) begin
            row_m1_q <= row_tiles_m1;
            col_m1_q <= col_tiles_m1;
            k_m1_q   <= k_tiles_m1;
            addr_q   <= base_addr;
        end else if (state_q == ADVANCE) begin
            addr_q <= cnt_last ? '0 : addr_q + ADDR_WIDTH'(TILE_STRIDE);
        end
    end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler
// Drives the tile scheduler against a registered multiply-controller model with
// configurable latency, records every issued job, and compares the job stream
// against a nested-loop reference built from the configuration.
module tb_matmul_tile_scheduler;
    import matmul_tile_scheduler_pkg::*;

    localparam int AW     = 128;
    localparam int IW     = 3;
    localparam int STRIDE = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] row_m1, col_m1, k_m1;
    logic [AW-1:0] base_addr;
    logic          busy, done;

    int n_compared = 0;
    int n_mismatch = 0;

    matmul_tile_scheduler_if #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW)) ctrl_if ();

    matmul_tile_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .row_tiles_m1 (row_m1),
        .col_tiles_m1 (col_m1),
        .k_tiles_m1   (k_m1),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .ctrl         (ctrl_if)
    );

    always #5 clk = ~clk;

    // Controller model: registered, drops mult_done the edge after a request
    // and raises it again after 'latency' cycles; force_low holds it busy.
    int   latency = 5;
    int   busy_cnt;
    logic force_low;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (ctrl_if.mult_active) begin
            busy_cnt <= latency;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign ctrl_if.mult_done = (busy_cnt == 0) && !force_low;

    typedef struct {
        logic [IW-1:0] row;
        logic [IW-1:0] col;
        logic [IW-1:0] k;
        logic          first;
        logic [AW-1:0] addr;
    } job_t;

    job_t jobs[$];
    int   done_count;

    // Job/done monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (ctrl_if.mult_active) begin
                jobs.push_back('{ctrl_if.submatrix_row, ctrl_if.submatrix_col,
                                 ctrl_if.k_idx, ctrl_if.accum_first, ctrl_if.job_addr});
            end
            if (done) begin
                done_count++;
            end
        end
    end

    typedef struct {
        logic [IW-1:0] r, c, k;
        logic [AW-1:0] base;
        int            lat;
        int            exp_jobs;
        logic [AW-1:0] exp_last_addr;
        logic [IW-1:0] exp_last_r, exp_last_c, exp_last_k;
    } vec_t;

    vec_t vecs[4];

    task automatic check_output(input string name, input logic [AW-1:0] actual,
                                input logic [AW-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"},        AW'(busy), 1);
        check_output({tag, "_busy"},        AW'(busy), 0);
        n_compared--;
        n_mismatch -= (busy !== 1'b1) ? 0 : 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_busy"},        AW'(busy), 0);
        check_output({tag, "_done"},        AW'(done), 0);
        check_output({tag, "_mult_active"}, AW'(ctrl_if.mult_active), 0);
        check_output({tag, "_row"},         AW'(ctrl_if.submatrix_row), 0);
        check_output({tag, "_col"},         AW'(ctrl_if.submatrix_col), 0);
        check_output({tag, "_k_idx"},       AW'(ctrl_if.k_idx), 0);
        check_output({tag, "_accum_first"}, AW'(ctrl_if.accum_first), 1);
        check_output({tag, "_job_addr"},    ctrl_if.job_addr, 0);
    endtask

    task automatic wait_for_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        bit seen;
        jobs.delete();
        done_count = 0;
        latency    = v.lat;
        row_m1     = v.r;
        col_m1     = v.c;
        k_m1       = v.k;
        base_addr  = v.base;
        start      = 1'b1;
        step();
        start      = 1'b0;
        check_output("start_to_active", AW'(ctrl_if.mult_active), 1);
        wait_for_done(seen);
        check_output("done_seen", AW'(seen), 1);
        step();
        check_output("done_one_cycle", AW'(done), 0);
        check_output("busy_after_done", AW'(busy), 0);
        repeat (2) step();
    endtask

    task automatic check_jobs(input vec_t v);
        int            idx;
        int            n;
        logic [9:0]    exp_c;
        logic [9:0]    got_c;
        logic [AW-1:0] exp_a;
        n = jobs.size();
        check_output("job_count", AW'(n), AW'(v.exp_jobs));
        check_output("done_count", AW'(done_count), 1);
        if (n > 0) begin
            check_output("last_addr", jobs[n-1].addr, v.exp_last_addr);
            check_output("last_coords", AW'({jobs[n-1].row, jobs[n-1].col, jobs[n-1].k}),
                         AW'({v.exp_last_r, v.exp_last_c, v.exp_last_k}));
        end
        idx = 0;
        for (int r = 0; r <= int'(v.r); r++) begin
            for (int c = 0; c <= int'(v.c); c++) begin
                for (int k = 0; k <= int'(v.k); k++) begin
                    exp_c = {r[2:0], c[2:0], k[2:0], (k == 0)};
                    exp_a = v.base + AW'(idx) * AW'(STRIDE);
                    if (idx < n) begin
                        got_c = {jobs[idx].row, jobs[idx].col, jobs[idx].k, jobs[idx].first};
                        check_output($sformatf("job%0d_coords", idx), AW'(got_c), AW'(exp_c));
                        check_output($sformatf("job%0d_addr", idx), jobs[idx].addr, exp_a);
                    end
                    idx++;
                end
            end
        end
    endtask

    initial begin
        bit seen;
        bit done_during;

        vecs[0] = '{r: 3'd0, c: 3'd0, k: 3'd0, base: 128'h100, lat: 5, exp_jobs: 1,
                    exp_last_addr: 128'h100, exp_last_r: 3'd0, exp_last_c: 3'd0, exp_last_k: 3'd0};
        vecs[1] = '{r: 3'd1, c: 3'd1, k: 3'd1, base: 128'h1000, lat: 3, exp_jobs: 8,
                    exp_last_addr: 128'h1700, exp_last_r: 3'd1, exp_last_c: 3'd1, exp_last_k: 3'd1};
        vecs[2] = '{r: 3'd2, c: 3'd0, k: 3'd1, base: 128'h0, lat: 1, exp_jobs: 6,
                    exp_last_addr: 128'h500, exp_last_r: 3'd2, exp_last_c: 3'd0, exp_last_k: 3'd1};
        vecs[3] = '{r: 3'd7, c: 3'd7, k: 3'd7,
                    base: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_F000, lat: 1, exp_jobs: 512,
                    exp_last_addr: 128'h1EF00, exp_last_r: 3'd7, exp_last_c: 3'd7, exp_last_k: 3'd7};

        reset      = 1'b1;
        start      = 1'b0;
        force_low  = 1'b0;
        row_m1     = '0;
        col_m1     = '0;
        k_m1       = '0;
        base_addr  = '0;
        done_count = 0;
        repeat (3) step();
        check_idle_outputs("reset");
        reset = 1'b0;
        step();
        check_idle_outputs("post_reset");

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d: R=%0d C=%0d K=%0d", i, vecs[i].r, vecs[i].c, vecs[i].k);
            apply_stimulus(vecs[i]);
            check_jobs(vecs[i]);
        end

        // Reset while the controller is busy on the first job
        $display("[TB] reset during WAIT_DONE");
        jobs.delete();
        done_count = 0;
        latency    = 10;
        row_m1     = 3'd1;
        col_m1     = 3'd1;
        k_m1       = 3'd1;
        base_addr  = 128'h4000;
        start      = 1'b1;
        step();
        start      = 1'b0;
        repeat (3) step();
        check_output("pre_reset_busy", AW'(busy), 1);
        check_output("pre_reset_addr", ctrl_if.job_addr, 128'h4000);
        reset = 1'b1;
        step();
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        done_during = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) done_during = 1'b1;
        end
        check_output("no_done_after_abort", AW'(done_during), 0);
        check_output("abort_busy", AW'(busy), 0);
        check_output("abort_done_count", AW'(done_count), 0);

        // start held and toggled while busy: exactly one run of two jobs
        $display("[TB] start held / toggled while busy");
        jobs.delete();
        done_count = 0;
        latency    = 3;
        row_m1     = 3'd0;
        col_m1     = 3'd1;
        k_m1       = 3'd0;
        base_addr  = 128'h200;
        start      = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (done === 1'b1) begin
                seen  = 1'b1;
                start = 1'b0;
            end else if (i >= 4) begin
                start = ~start;
            end
        end
        start = 1'b0;
        check_output("held_done_seen", AW'(seen), 1);
        repeat (10) step();
        check_output("held_busy", AW'(busy), 0);
        check_output("held_job_count", AW'(jobs.size()), 2);
        check_output("held_done_count", AW'(done_count), 1);
        if (jobs.size() == 2) begin
            check_output("held_job1_addr", jobs[1].addr, 128'h300);
        end

        // Controller not in HOLD when start arrives
        $display("[TB] mult_done low at start");
        jobs.delete();
        done_count = 0;
        latency    = 2;
        row_m1     = 3'd0;
        col_m1     = 3'd0;
        k_m1       = 3'd0;
        base_addr  = 128'h800;
        force_low  = 1'b1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("held_off_active%0d", i), AW'(ctrl_if.mult_active), 0);
            check_output($sformatf("held_off_busy%0d", i), AW'(busy), 1);
            step();
        end
        force_low = 1'b0;
        step();
        check_output("released_active", AW'(ctrl_if.mult_active), 1);
        wait_for_done(seen);
        check_output("released_done_seen", AW'(seen), 1);
        repeat (3) step();
        check_output("released_job_count", AW'(jobs.size()), 1);
        check_output("released_done_count", AW'(done_count), 1);
        if (jobs.size() == 1) begin
            check_output("released_addr", jobs[0].addr, 128'h800);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
